// File: rtl/io_write_arbiter.sv
// Round-robin arbiter that shares the display output-port write bus between NREQ requesters.
// Each grant issues exactly one write; unmapped addresses are consumed and flagged on err.
module io_write_arbiter #(
    parameter int NREQ    = 3,
    parameter int GAP_CYC = 0
) (
    input  logic                 io_clk,
    input  logic                 clrn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [31:0]          io_addr,
    output logic [31:0]          io_data,
    output logic                 write_io_enable,
    output logic                 err,
    output logic                 busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, GAP = 2'd2} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [3:0]      gap_cnt_reg, gap_cnt_next;

    logic [NREQ-1:0] gnt_next;
    logic [31:0]     io_addr_next, io_data_next;
    logic            wen_next, err_next, busy_next;

    logic [NREQ-1:0] at_or_above, upper_req, cand_req, pick_oh;
    logic [PW-1:0]   sel_idx;
    logic [31:0]     sel_addr, sel_data;
    logic            sel_mapped, take;

    // Requesters at or above the pointer win first; otherwise wrap to the lowest set index.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign at_or_above[gi] = (PW'(gi) >= rr_ptr_reg);
        end
    endgenerate

    assign upper_req = req & at_or_above;
    assign cand_req  = (|upper_req) ? upper_req : req;
    assign pick_oh   = cand_req & (~cand_req + NREQ'(1));

    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (pick_oh[j]) begin
                sel_idx  = PW'(j);
                sel_addr = req_addr[j*32 +: 32];
                sel_data = req_data[j*32 +: 32];
            end
        end
    end

    assign sel_mapped = (sel_addr[7:2] == 6'h20) || (sel_addr[7:2] == 6'h21) ||
                        (sel_addr[7:2] == 6'h22);
    assign take       = (state_reg == IDLE) && (|req);

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            gap_cnt_reg     <= '0;
            gnt             <= '0;
            io_addr         <= '0;
            io_data         <= '0;
            write_io_enable <= 1'b0;
            err             <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rr_ptr_reg      <= rr_ptr_next;
            gap_cnt_reg     <= gap_cnt_next;
            gnt             <= gnt_next;
            io_addr         <= io_addr_next;
            io_data         <= io_data_next;
            write_io_enable <= wen_next;
            err             <= err_next;
            busy            <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        gap_cnt_next = gap_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (take) begin
                    state_next  = WRITE;
                    rr_ptr_next = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
                end
            end
            WRITE: begin
                if (GAP_CYC == 0) begin
                    state_next = IDLE;
                end else begin
                    state_next   = GAP;
                    gap_cnt_next = 4'(GAP_CYC - 1);
                end
            end
            GAP: begin
                if (gap_cnt_reg == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address/data only update on a new grant so the bus holds the last write afterwards.
    always_comb begin
        gnt_next     = take ? pick_oh : '0;
        io_addr_next = take ? sel_addr : io_addr;
        io_data_next = take ? sel_data : io_data;
        wen_next     = take && sel_mapped;
        err_next     = take && !sel_mapped;
        busy_next    = (state_next != IDLE);
    end
endmodule
